alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Multi-cycle execute unit; consumes the 4-bit ALUControl code produced by the ALU decoder, together with two operands, and returns the result.
- Logic, arithmetic and compare ops complete in one cycle. Shifts use an iterative 1-bit-per-cycle shifter, saving barrel-shifter area.
- Sits between decode/operand-fetch and writeback. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHW, $clog2(WIDTH) (5), shift-amount width; taken from src_b[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of any op in flight
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept an operation
- alu_ctrl  input  4  operation code (see Behaviour)
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B / shift amount
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- illegal  output  1  alu_ctrl was not a defined code

Behaviour:
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA
  - 1000 SLT (signed), 1001 SLTU (unsigned); result is 1 or 0, zero-extended.
  - 1010–1111 are illegal: result = 0, zero = 1, illegal = 1, latency 1.
- ADD/SUB wrap modulo 2^WIDTH. No overflow or carry outputs.
- FSM states: IDLE, SHIFT, DONE.
- Reset (async, rst_n low): state = IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, illegal = 0, shift counter = 0.
- in_ready = (state == IDLE). Accept occurs on a clock edge where in_valid && in_ready. Operands and code are sampled only at accept.
- IDLE, non-shift code accepted: result, zero and illegal are registered at that edge; next state DONE. out_valid is high in the cycle after accept (latency 1).
- IDLE, shift accepted with n = src_b[SHW-1:0]:
  - n == 0: result = src_a; go to DONE, latency 1.
  - n > 0: load work register with src_a and counter with n; go to SHIFT.
- SHIFT: each cycle shift by one bit and decrement the counter.
  - SLL fills with 0; SRL fills with 0; SRA fills with the sign bit.
  - When counter == 1, transfer to result and go to DONE.
  - SHIFT occupies exactly n cycles; out_valid rises n+1 cycles after the accept edge.
  - Upper bits of src_b are ignored.
- DONE: out_valid = 1; result, zero and illegal are held stable until out_ready. On an edge with out_valid && out_ready, go to IDLE. in_ready rises the following cycle, so minimum throughput is one op per 2 cycles.
- flush: when high at an edge, go to IDLE and drop out_valid, whatever the state; any pending result is discarded.
  - flush has priority over accept and over the out_ready handshake in the same cycle.
  - result retains its last value (don't-care while out_valid = 0).
- rst_n asserted mid-SHIFT or in DONE: outputs go to reset values immediately (asynchronously). No partial result is ever presented.
- in_valid while in SHIFT/DONE: ignored (in_ready low). The upstream stage must hold its operation.
- zero is computed from the final result for every code, including shifts and compares.

Test Plan:
- ADD 5+7 (ctrl 0010), out_ready=1 -> out_valid one cycle after accept, result=12, zero=0, illegal=0. SUB 3−3 (0011) -> result=0, zero=1.
- SRA src_a=0x80000000, src_b=4 (0111) -> in_ready low 5 cycles, out_valid 5 cycles after accept, result=0xF8000000. Repeat as SRL -> 0x08000000. SLL 1 by 31 -> 0x80000000, 32-cycle latency.
- SLT a=0xFFFFFFFF, b=1 (1000) -> result=1. SLTU same operands (1001) -> result=0, zero=1. SLL with src_b=0x20 (n=0) -> result=src_a, latency 1.
- Backpressure: ADD 1+1 with out_ready held low 3 cycles -> result=2 and out_valid stay stable, in_ready=0, new in_valid ignored. out_ready high -> handshake, in_ready=1 next cycle.
- Illegal ctrl 1111, a=0x1234 -> result=0, zero=1, illegal=1, latency 1.
- flush asserted on the 3rd cycle of SLL by 10 -> IDLE next cycle, out_valid never rises, in_ready=1. rst_n pulsed low mid-SRA -> out_valid=0, result=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Multi-cycle execute unit sitting between decode/operand-fetch and
// writeback. Logic, arithmetic and compare operations finish in one cycle.
// Shifts are done by an iterative shifter that moves one bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of any operation in flight
//   in_valid   operation offered by upstream
//   in_ready   unit can accept an operation (high only in IDLE)
//   alu_ctrl   4-bit operation code from the ALU decoder
//   src_a      operand A
//   src_b      operand B; shift amount comes from src_b[SHW-1:0]
//   out_valid  result available (high only in DONE)
//   out_ready  downstream takes the result
//   result     operation result
//   zero       result == 0
//   illegal    alu_ctrl was not a defined code
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Low two bits of the shift codes 0101/0110/0111.
    localparam logic [1:0] SOP_SLL = 2'b01;
    localparam logic [1:0] SOP_SRL = 2'b10;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             zero_q,    zero_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] work_q,    work_d;
    logic [SHW-1:0]   cnt_q,     cnt_d;
    logic [1:0]       sop_q,     sop_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shifted;
    logic             is_shift;
    logic             is_illegal;
    logic [SHW-1:0]   shamt;

    assign shamt      = src_b[SHW-1:0];
    assign is_shift   = (alu_ctrl == 4'b0101) || (alu_ctrl == 4'b0110) ||
                        (alu_ctrl == 4'b0111);
    assign is_illegal = (alu_ctrl >= 4'b1010);

    // Single-cycle datapath; illegal codes produce 0.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            4'b0000: alu_res = src_a & src_b;
            4'b0001: alu_res = src_a | src_b;
            4'b0010: alu_res = src_a + src_b;
            4'b0011: alu_res = src_a - src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b1000: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        case (sop_q)
            SOP_SLL: shifted = {work_q[WIDTH-2:0], 1'b0};
            SOP_SRL: shifted = {1'b0, work_q[WIDTH-1:1]};
            default: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        sop_d     = sop_q;

        if (flush) begin
            // Kill wins over accept and over the output handshake; result keeps
            // its last value since out_valid is low anyway.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_shift && (shamt != '0)) begin
                            work_d  = src_a;
                            cnt_d   = shamt;
                            sop_d   = alu_ctrl[1:0];
                            state_d = S_SHIFT;
                        end else begin
                            // A zero-length shift passes src_a straight through.
                            result_d  = is_shift ? src_a : alu_res;
                            zero_d    = is_shift ? (src_a == '0) : (alu_res == '0);
                            illegal_d = is_illegal;
                            state_d   = S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work_d = shifted;
                    cnt_d  = cnt_q - 1'b1;
                    // Last step: publish the result in the same edge so SHIFT
                    // lasts exactly n cycles.
                    if (cnt_q == SHW'(1)) begin
                        result_d  = shifted;
                        zero_d    = (shifted == '0);
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            work_q    <= '0;
            cnt_q     <= '0;
            sop_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            sop_q     <= sop_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed vectors with hand-computed expectations. The driver pushes the
// expected result, flags and the cycle in which out_valid should first appear
// into a queue; a monitor on the falling edge pops an entry on each output
// handshake and compares. Flush, reset and backpressure are checked inline.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          first;   // cycle index in which out_valid first shows
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   first_cyc = 0;
    bit   ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (out_valid && !ov_prev) first_cyc = cyc;
        ov_prev = out_valid;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result 0x%08h with no pending op", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check32({e.name, "_result"},  result,            e.res);
                check32({e.name, "_zero"},    {31'b0, zero},     {31'b0, e.z});
                check32({e.name, "_illegal"}, {31'b0, illegal},  {31'b0, e.ill});
                check32({e.name, "_latency"}, 32'(first_cyc),    32'(e.first));
                $display("op %s: result=0x%08h zero=%0b illegal=%0b first_valid_cycle=%0d",
                         e.name, result, zero, illegal, first_cyc);
            end
        end
    end

    // Called at posedge+1; waits for in_ready, then offers the op for one edge.
    // lat is the expected latency: out_valid is first seen lat cycles after
    // the accept edge (i.e. in cycle index accept+lat-1 as counted here).
    task automatic issue(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez,
                         input logic ei, input int lat, input bit push);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: in_ready=%0b required 1", nm, in_ready);
            return;
        end
        alu_ctrl = c;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        if (push) sb.push_back('{nm, er, ez, ei, cyc + lat});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        alu_ctrl  = 4'b0;
        src_a     = 32'b0;
        src_b     = 32'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_in_ready",  {31'b0, in_ready},  32'd1);
        check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check32("reset_result",    result,             32'd0);
        check32("reset_zero",      {31'b0, zero},      32'd0);
        check32("reset_illegal",   {31'b0, illegal},   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //     name          ctrl     src_a         src_b         result        z     ill   lat
        issue("add",        4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1,  1'b1);
        issue("sub",        4'b0011, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0, 1,  1'b1);
        issue("add_wrap",   4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1,  1'b1);
        issue("and",        4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1,  1'b1);
        issue("or",         4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1,  1'b1);
        issue("xor",        4'b0100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0, 1,  1'b1);
        issue("sra4",       4'b0111, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 5,  1'b1);
        issue("srl4",       4'b0110, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 5,  1'b1);
        issue("sll31",      4'b0101, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b0, 32, 1'b1);
        issue("sra3_pos",   4'b0111, 32'h40000000, 32'd3,        32'h08000000, 1'b0, 1'b0, 4,  1'b1);
        issue("sra1",       4'b0111, 32'hF0000001, 32'd1,        32'hF8000000, 1'b0, 1'b0, 2,  1'b1);
        issue("srl_to_zero",4'b0110, 32'h00000008, 32'h000000E4, 32'h00000000, 1'b1, 1'b0, 5,  1'b1);
        issue("slt",        4'b1000, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1,  1'b1);
        issue("sltu",       4'b1001, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1,  1'b1);
        issue("sll_n0",     4'b0101, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0, 1'b0, 1,  1'b1);
        issue("illegal_f",  4'b1111, 32'h00001234, 32'd9,        32'd0,        1'b1, 1'b1, 1,  1'b1);
        issue("illegal_a",  4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b1, 1,  1'b1);
        issue("add_after",  4'b0010, 32'd100,      32'd23,       32'd123,      1'b0, 1'b0, 1,  1'b1);
        drain();

        // Backpressure: result must hold while out_ready is low, and a new
        // offer must be ignored.
        out_ready = 1'b0;
        issue("add_bp", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            alu_ctrl = 4'b0010;
            src_a    = 32'd9;
            src_b    = 32'd9;
            in_valid = 1'b1;
            @(negedge clk);
            check32("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check32("bp_result",    result,             32'd2);
            check32("bp_in_ready",  {31'b0, in_ready},  32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check32("bp_in_ready_after", {31'b0, in_ready},  32'd1);
        check32("bp_out_valid_after",{31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        drain();

        // Flush on the third cycle of SLL by 10: the op must vanish.
        issue("sll10_flush", 4'b0101, 32'd1, 32'd10, 32'd0, 1'b0, 1'b0, 11, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check32("flush_in_ready",  {31'b0, in_ready},  32'd1);
        check32("flush_out_valid", {31'b0, out_valid}, 32'd0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check32("flush_no_output", {31'b0, seen}, 32'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset in the middle of SRA by 8; result is nonzero
        // beforehand (0x00000FF0 from XOR... later ops), so clearing is visible.
        issue("add_pre_rst", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1, 1'b1);
        drain();
        issue("sra8_rst", 4'b0111, 32'h80000000, 32'd8, 32'd0, 1'b0, 1'b0, 9, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check32("rst_result",    result,             32'd0);
        check32("rst_zero",      {31'b0, zero},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check32("rst_in_ready_after", {31'b0, in_ready}, 32'd1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check32("rst_no_partial_output", {31'b0, seen}, 32'd0);
        end
        @(posedge clk); #1;

        issue("add_post_rst", 4'b0011, 32'd10, 32'd4, 32'd6, 1'b0, 1'b0, 1, 1'b1);
        drain();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
